inverse_difference_equation: RTL
================================

Name: inverse_difference_equation

Overview:
Streaming inverse, or deconvolution, filter for the team's 2nd-order difference-equation filter y[n] = x[n] − x[n−1] + x[n−2] + x[n−3] + 0.5y[n−1] + 0.25y[n−2].
It recovers x[n] = y[n] − (y[n−1]>>>1) − (y[n−2]>>>2) + x[n−1] − x[n−2] − x[n−3] from the filter's output stream.
It sits on the receive side of a filter link and uses valid/ready handshakes on both ends.
It uses one shared adder, sequenced by an FSM, with saturation to the original sample width.

Parameters:
N_BITS, 8, width of the recovered sample x (two's complement).
ACC_BITS, N_BITS+6, internal accumulator width; must be ≥ N_BITS+5.

Ports:
clock  in  1  rising-edge clock.
i_reset  in  1  synchronous, active-high reset.
i_y  in  N_BITS+3  filtered sample y[n], signed two's complement.
i_valid  in  1  i_y valid.
o_ready  out  1  block can accept i_y.
o_x  out  N_BITS  recovered sample x[n], signed, saturated.
o_sat  out  1  o_x was clipped; qualified by o_valid.
o_valid  out  1  o_x/o_sat valid.
i_ready  in  1  downstream accepts o_x.

Behaviour:
- Reset is synchronous and active-high, on clock. While i_reset=1 at a rising edge:
  - state → IDLE.
  - o_valid=0, o_sat=0, o_x=0, o_ready=1 from the following cycle.
  - acc, step counter, y history (r_y0, r_y1, r_y2) and x history (r_x1, r_x2, r_x3) are all cleared to 0.
  - Reset mid-CALC or mid-OUT drops the in-flight sample. Nothing is emitted.
- States: IDLE, CALC, OUT.
- IDLE:
  - o_ready=1, o_valid=0.
  - On an edge with i_valid=1: r_y0 ← i_y (sign-extended to ACC_BITS), acc ← 0, step ← 0, state → CALC.
- CALC:
  - o_ready=0. Exactly 6 cycles, one term per edge into acc via the single adder/subtractor.
  - step 0: +r_y0
  - step 1: −(r_y1>>>1)
  - step 2: −(r_y2>>>2)
  - step 3: +r_x1
  - step 4: −r_x2
  - step 5: −r_x3
  - Shifts are arithmetic, rounding toward −∞ (floor), and match the forward filter.
  - On the step-5 edge the final sum S = acc ± term is evaluated:
    - o_x ← sat(S): clip to [−2^(N_BITS−1), 2^(N_BITS−1)−1].
    - o_sat ← (clip occurred). o_valid ← 1.
    - History updates: r_y2←r_y1, r_y1←r_y0, r_x3←r_x2, r_x2←r_x1, r_x1←sat(S). The saturated value is fed back.
    - state → OUT.
- OUT:
  - o_valid=1, o_ready=0. o_x and o_sat are held stable until an edge with i_ready=1.
  - On that edge: o_valid←0, state→IDLE.
  - i_valid is ignored in CALC and OUT. The upstream holds its data because o_ready=0.
- Latency: accept edge E0 → o_valid high after E6 (6 cycles).
- Throughput: at most 1 sample per 8 cycles with i_ready tied high (E0 accept, E6 result, E7 transfer, E8 next accept).
- No combinational path from i_ready to o_ready or from i_valid to o_valid. All outputs come straight from registers.
- Width: ACC_BITS holds the worst case |y|+|y/2|+|y/4|+3·2^(N_BITS−1) without overflow. Any overflow is a parameter error.
- The history advances only on completed samples. Back-pressure does not disturb the history.

Test Plan:
1. Impulse round-trip (N_BITS=8): after reset, feed y = 10, −5, 9, 12 (forward filter response to x = 10, 0, 0, 0) → o_x = 10, 0, 0, 0, with o_sat=0 each time.
2. Latency/handshake: i_valid=1 and i_ready=1 held, y=10 → o_ready low the cycle after accept; o_valid rises exactly 6 cycles after the accept edge; next accept occurs 8 cycles after the first.
3. Saturation: after reset, y=1023 → o_x=127, o_sat=1. Then y=0 → S = 0−511−0+127 = −384 → o_x=−128, o_sat=1.
4. Back-pressure: during OUT hold i_ready=0 for 5 cycles while toggling i_valid/i_y → o_x and o_sat are stable, o_ready=0, no sample is accepted. Then i_ready=1 → transfer, and o_ready=1 the next cycle.
5. Reset mid-CALC: accept y=100, assert i_reset at CALC step 3 → no o_valid. Then feed y=10 → o_x=10, proving the history was cleared.
6. Negative floor check: after reset, feed y = −3, 0 → o_x = −3, then 0 − floor(−1.5) − 0 + (−3) = −1.

Source files
------------

// File: rtl/inverse_difference_equation.sv
// Streaming deconvolution filter. It undoes y[n] = x[n] - x[n-1] + x[n-2] + x[n-3] + y[n-1]/2 + y[n-2]/4
// by accumulating one term per cycle through a single shared adder/subtractor.
module inverse_difference_equation #(
  parameter int N_BITS   = 8,
  parameter int ACC_BITS = N_BITS + 6
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic signed [N_BITS+2:0] i_y,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [N_BITS-1:0] o_x,
  output logic                     o_sat,
  output logic                     o_valid,
  input  logic                     i_ready
);

  // Handshake: a word moves on any rising edge where valid and ready are both high.
  // Once raised, o_valid, o_x and o_sat hold until that edge. o_ready is registered,
  // so it never depends combinationally on i_valid or i_ready.
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  localparam logic signed [N_BITS-1:0]   X_MAX_N = {1'b0, {(N_BITS-1){1'b1}}};
  localparam logic signed [N_BITS-1:0]   X_MIN_N = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic signed [ACC_BITS-1:0] X_MAX   = {{(ACC_BITS-N_BITS+1){1'b0}}, {(N_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] X_MIN   = {{(ACC_BITS-N_BITS+1){1'b1}}, {(N_BITS-1){1'b0}}};

  state_t                     state, state_next;
  logic [2:0]                 step;
  logic signed [ACC_BITS-1:0] acc, r_y0, r_y1, r_y2;
  logic signed [ACC_BITS-1:0] y_ext, term, sum;
  logic signed [N_BITS-1:0]   r_x1, r_x2, r_x3, x_sat;
  logic                       sub, clip_hi, clip_lo;
  logic                       accept, last_step, transfer;

  function automatic logic signed [ACC_BITS-1:0] sext_x(input logic signed [N_BITS-1:0] v);
    return {{(ACC_BITS-N_BITS){v[N_BITS-1]}}, v};
  endfunction

  assign y_ext = {{(ACC_BITS-N_BITS-3){i_y[N_BITS+2]}}, i_y};

  // Term selection for the shared adder. The >>> shifts floor, which matches the forward filter.
  always_comb begin
    term = '0;
    sub  = 1'b0;
    case (step)
      3'd0: term = r_y0;
      3'd1: begin term = r_y1 >>> 1; sub = 1'b1; end
      3'd2: begin term = r_y2 >>> 2; sub = 1'b1; end
      3'd3: term = sext_x(r_x1);
      3'd4: begin term = sext_x(r_x2); sub = 1'b1; end
      3'd5: begin term = sext_x(r_x3); sub = 1'b1; end
      default: term = '0;
    endcase
    sum     = sub ? (acc - term) : (acc + term);
    clip_hi = (sum > X_MAX);
    clip_lo = (sum < X_MIN);
    x_sat   = clip_hi ? X_MAX_N : (clip_lo ? X_MIN_N : sum[N_BITS-1:0]);
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: if (i_valid) begin
        accept     = 1'b1;
        state_next = CALC;
      end
      CALC: if (step == 3'd5) begin
        last_step  = 1'b1;
        state_next = OUT;
      end
      OUT: if (i_ready) begin
        transfer   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
      o_x     <= '0;
      acc     <= '0;
      step    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_y2    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_x3    <= '0;
    end else begin
      state   <= state_next;
      o_ready <= (state_next == IDLE);
      if (accept) begin
        r_y0 <= y_ext;
        acc  <= '0;
        step <= '0;
      end
      if (state == CALC) begin
        acc  <= sum;
        step <= step + 3'd1;
      end
      // The history advances only when a sample completes; the clipped value is fed back.
      if (last_step) begin
        o_x     <= x_sat;
        o_sat   <= clip_hi | clip_lo;
        o_valid <= 1'b1;
        r_y2    <= r_y1;
        r_y1    <= r_y0;
        r_x3    <= r_x2;
        r_x2    <= r_x1;
        r_x1    <= x_sat;
      end
      if (transfer) o_valid <= 1'b0;
    end
  end

endmodule
